// File: rtl/serial_addsub.sv
// Bit-serial adder/subtractor: one full-adder slice plus a carry register,
// processing WIDTH-bit operands LSB first, one bit per clock.
module serial_addsub #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int CNT_W = $clog2(WIDTH) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_PRE  = CNT_W'(WIDTH - 2);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t r_state;
  state_t w_next;

  logic             w_load;
  logic             w_step;
  logic             w_last;

  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic             r_carry;
  logic             r_cmsb;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-2:0] r_res;

  logic             w_s;
  logic             w_cnew;
  logic [WIDTH-1:0] w_res_nxt;

  // Full-adder slice on the current LSBs, and the result register's next value.
  always_comb begin
    w_s       = r_a[0] ^ r_b[0] ^ r_carry;
    w_cnew    = (r_a[0] & r_b[0]) | (r_a[0] & r_carry) | (r_b[0] & r_carry);
    w_res_nxt = {w_s, r_res};
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic and datapath control strobes.
  always_comb begin
    w_next = r_state;
    w_load = 1'b0;
    w_step = 1'b0;
    w_last = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_load = 1'b1;
          w_next = S_RUN;
        end
      end
      S_RUN: begin
        w_step = 1'b1;
        if (r_cnt == CNT_LAST) begin
          w_last = 1'b1;
          w_next = S_DONE;
        end
      end
      S_DONE: begin
        if (start) begin
          w_load = 1'b1;
          w_next = S_RUN;
        end else begin
          w_next = S_IDLE;
        end
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  // Operand shifters, carry, bit counter and partial result.
  // The counter holds at WIDTH-1 on the final edge instead of wrapping past it;
  // it is cleared on every load, so nothing observes the difference.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a     <= '0;
      r_b     <= '0;
      r_carry <= 1'b0;
      r_cmsb  <= 1'b0;
      r_cnt   <= '0;
      r_res   <= '0;
    end else if (w_load) begin
      r_a     <= a;
      r_b     <= sub ? ~b : b;
      r_carry <= sub ? 1'b1 : cin;
      r_cnt   <= '0;
    end else if (w_step) begin
      r_a     <= r_a >> 1;
      r_b     <= r_b >> 1;
      r_carry <= w_cnew;
      r_res   <= w_res_nxt[WIDTH-1:1];
      if (!w_last) begin
        r_cnt <= r_cnt + 1'b1;
      end
      if (r_cnt == CNT_PRE) begin
        r_cmsb <= w_cnew;
      end
    end
  end

  // Registered outputs; results change only on the completion edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy <= 1'b0;
      done <= 1'b0;
      sum  <= '0;
      cout <= 1'b0;
      ovf  <= 1'b0;
    end else begin
      busy <= (w_next == S_RUN);
      done <= w_last;
      if (w_last) begin
        sum  <= w_res_nxt;
        cout <= w_cnew;
        ovf  <= r_cmsb ^ w_cnew;
      end
    end
  end

endmodule
